// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

    localparam int INSN_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/imem_fetch_resp_if.sv
// Fetch request/response channel between the CPU fetch stage and instruction memory.
interface imem_fetch_resp_if
    import imem_pkg::*;
#(
    parameter int AW = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [AW-1:0]     req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [INSN_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/imem_ram_1r1w.sv
// Instruction word array: registered read port, one write port, writes beyond DEPTH dropped.
module imem_ram_1r1w
    import imem_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DEPTH = 256,
    parameter int IW    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [IW-1:0]     rd_idx,
    output logic [INSN_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [INSN_W-1:0] wr_data
);
    logic [INSN_W-1:0] mem [DEPTH];

    // Only the read register is reset; array contents survive reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < (AW + 1)'(DEPTH))) begin
            mem[wr_addr[IW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/imem_fetch_resp.sv
// Instruction-memory responder: one fetch outstanding, fixed LAT wait states per request.
// Build option IMEM_ERR_EN: fetches at or beyond DEPTH return rsp_err=1 with zero data.
//
// state | meaning
// IDLE  | ready for a fetch request (a loader write blocks acceptance)
// WAIT  | down-counting wait states, RESP entered when the count reaches 1
// RESP  | instruction word held on rsp_data until the CPU takes it
module imem_fetch_resp
    import imem_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DEPTH = 256,
    parameter int LAT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    imem_fetch_resp_if.slave  bus,
    input  logic              ld_we,
    input  logic [AW-1:0]     ld_addr,
    input  logic [INSN_W-1:0] ld_data,
    output logic              busy
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [AW-1:0]     addr_q;
    logic              rsp_valid_q;
    logic              accept;
    logic              enter_resp;
    logic              rsp_hs;
    logic [AW-1:0]     rd_addr;
    logic [IW-1:0]     rd_idx;
    logic [INSN_W-1:0] rd_data;

    assign bus.req_ready = (state == IDLE) && !ld_we;
    assign accept        = bus.req_valid && bus.req_ready;
    assign rsp_hs        = (state == RESP) && bus.rsp_ready;
    assign enter_resp    = ((state == IDLE) && accept && (LAT == 0)) ||
                           ((state == WAIT) && (cnt == CNT_W'(1)));

    // With zero wait states the array is read on the accept edge itself.
    assign rd_addr = (state == IDLE) ? bus.req_addr : addr_q;
    assign rd_idx  = IW'(32'(rd_addr) % 32'(DEPTH));

    assign busy          = (state != IDLE);
    assign bus.rsp_valid = rsp_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            addr_q      <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q <= bus.req_addr;
                        cnt    <= CNT_W'(LAT);
                        state  <= (LAT == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (enter_resp) begin
                rsp_valid_q <= 1'b1;
            end else if (rsp_hs) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    imem_ram_1r1w #(
        .AW    (AW),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (enter_resp),
        .rd_idx  (rd_idx),
        .rd_data (rd_data),
        .wr_en   (ld_we),
        .wr_addr (ld_addr),
        .wr_data (ld_data)
    );

`ifdef IMEM_ERR_EN
    logic rsp_err_q;
    logic rd_oor;

    assign rd_oor = ({1'b0, rd_addr} >= (AW + 1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_err_q <= 1'b0;
        end else if (enter_resp) begin
            rsp_err_q <= rd_oor;
        end else if (rsp_hs) begin
            rsp_err_q <= 1'b0;
        end
    end

    assign bus.rsp_err  = rsp_err_q;
    assign bus.rsp_data = rsp_err_q ? '0 : rd_data;
`else
    assign bus.rsp_err  = 1'b0;
    assign bus.rsp_data = rd_data;
`endif

endmodule
